// File: rtl/load_tag_allocator_if.sv
// rtl/load_tag_allocator_if.sv - alloc/response/flush bus of the load tag allocator
// master drives requests and responses; slave is the allocator.
interface load_tag_allocator_if #(
  parameter int NR_ENTRIES    = 2,
  parameter int TRANS_ID_BITS = 3
);
  localparam int TAG_BITS = (NR_ENTRIES == 1) ? 1 : $clog2(NR_ENTRIES);
  localparam int CNT_BITS = $clog2(NR_ENTRIES + 1);

  logic                     flush_i;
  logic                     alloc_valid_i;
  logic                     alloc_ready_o;
  logic [TRANS_ID_BITS-1:0] alloc_trans_id_i;
  logic [TAG_BITS-1:0]      alloc_tag_o;
  logic                     resp_valid_i;
  logic [TAG_BITS-1:0]      resp_tag_i;
  logic                     resp_valid_o;
  logic [TRANS_ID_BITS-1:0] resp_trans_id_o;
  logic                     resp_killed_o;
  logic                     resp_err_o;
  logic [CNT_BITS-1:0]      count_o;
  logic                     empty_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_trans_id_i, resp_valid_i, resp_tag_i,
    input  alloc_ready_o, alloc_tag_o, resp_valid_o, resp_trans_id_o,
           resp_killed_o, resp_err_o, count_o, empty_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_trans_id_i, resp_valid_i, resp_tag_i,
    output alloc_ready_o, alloc_tag_o, resp_valid_o, resp_trans_id_o,
           resp_killed_o, resp_err_o, count_o, empty_o
  );
endinterface

// File: rtl/load_tag_allocator.sv
// rtl/load_tag_allocator.sv - load-buffer tag allocator with flush-kill tracking
// Each entry is FREE, LIVE or KILLED; responses to KILLED entries are dropped.
module load_tag_allocator #(
  parameter int NR_ENTRIES    = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  load_tag_allocator_if.slave bus
);
  localparam int TAG_BITS = (NR_ENTRIES == 1) ? 1 : $clog2(NR_ENTRIES);
  localparam int CNT_BITS = $clog2(NR_ENTRIES + 1);

  logic [NR_ENTRIES-1:0]                    r_valid;
  logic [NR_ENTRIES-1:0]                    r_killed;
  logic [NR_ENTRIES-1:0][TRANS_ID_BITS-1:0] r_trans_id;
  logic [CNT_BITS-1:0]                      r_count;

  logic                     w_free_found;
  logic [TAG_BITS-1:0]      w_free_idx;
  logic                     w_alloc_ready;
  logic                     w_fire;
  logic [NR_ENTRIES-1:0]    w_resp_sel;
  logic [NR_ENTRIES-1:0]    w_alloc_sel;
  logic [NR_ENTRIES-1:0]    w_valid_nxt;
  logic [NR_ENTRIES-1:0]    w_killed_nxt;
  logic                     w_resp_live;
  logic                     w_resp_dead;
  logic [TRANS_ID_BITS-1:0] w_resp_tid;
  logic [CNT_BITS-1:0]      w_count_nxt;

  // Descending scan so the last hit is the lowest free index.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = TAG_BITS'(i);
      end
    end
  end

  assign w_alloc_ready = w_free_found && !bus.flush_i;
  assign w_fire        = bus.alloc_valid_i && w_alloc_ready;

  // Tags outside the entry range never select anything and so report as errors.
  always_comb begin
    w_resp_sel  = '0;
    w_alloc_sel = '0;
    w_resp_tid  = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      w_resp_sel[i]  = bus.resp_valid_i && (bus.resp_tag_i == TAG_BITS'(i));
      w_alloc_sel[i] = w_fire && (w_free_idx == TAG_BITS'(i));
      if (w_resp_sel[i]) w_resp_tid = r_trans_id[i];
    end
  end

  assign w_resp_live = |(w_resp_sel & r_valid & ~r_killed);
  assign w_resp_dead = |(w_resp_sel & r_valid & r_killed);

  // A response in the flush cycle frees its entry instead of letting it be killed.
  assign w_valid_nxt  = (r_valid & ~w_resp_sel) | w_alloc_sel;
  assign w_killed_nxt = w_valid_nxt & ~w_alloc_sel & (r_killed | {NR_ENTRIES{bus.flush_i}});

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      w_count_nxt = w_count_nxt + CNT_BITS'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= '0;
      r_killed   <= '0;
      r_trans_id <= '0;
      r_count    <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_killed <= w_killed_nxt;
      r_count  <= w_count_nxt;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (w_alloc_sel[i]) r_trans_id[i] <= bus.alloc_trans_id_i;
      end
    end
  end

  assign bus.alloc_ready_o   = w_alloc_ready;
  assign bus.alloc_tag_o     = w_free_idx;
  assign bus.resp_valid_o    = w_resp_live;
  assign bus.resp_trans_id_o = w_resp_live ? w_resp_tid : '0;
  assign bus.resp_killed_o   = w_resp_dead;
  assign bus.resp_err_o      = bus.resp_valid_i && !w_resp_live && !w_resp_dead;
  assign bus.count_o         = r_count;
  assign bus.empty_o         = (r_count == '0);

  // Responses to free entries are a load-unit protocol error worth flagging.
  cover property (@(posedge clk_i) disable iff (rst_i) bus.resp_err_o);

  assert property (@(posedge clk_i) disable iff (rst_i) int'(r_count) <= NR_ENTRIES);

endmodule

// File: tb/tb_load_tag_allocator.sv
// tb/tb_load_tag_allocator.sv - directed and randomized checks of load_tag_allocator
module tb_load_tag_allocator;
  localparam int NR  = 2;
  localparam int TID = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_tag_allocator_if #(.NR_ENTRIES(NR), .TRANS_ID_BITS(TID)) bus ();

  load_tag_allocator #(.NR_ENTRIES(NR), .TRANS_ID_BITS(TID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] aid, input logic rv,
                       input logic rt, input logic fl);
    bus.alloc_valid_i    = av;
    bus.alloc_trans_id_i = aid;
    bus.resp_valid_i     = rv;
    bus.resp_tag_i       = rt;
    bus.flush_i          = fl;
    #1;
  endtask

  logic       m_valid  [NR];
  logic       m_killed [NR];
  logic [2:0] m_tid    [NR];

  initial begin
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("rst_ready", bus.alloc_ready_o, 1);
    chk("rst_tag", bus.alloc_tag_o, 0);
    chk("rst_rvalid", bus.resp_valid_o, 0);
    chk("rst_killed", bus.resp_killed_o, 0);
    chk("rst_err", bus.resp_err_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_empty", bus.empty_o, 1);

    // 1: single alloc and response
    drive(1, 5, 0, 0, 0);
    chk("t1_tag", bus.alloc_tag_o, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("t1_count", bus.count_o, 1);
    chk("t1_empty", bus.empty_o, 0);
    chk("t1_rvalid", bus.resp_valid_o, 1);
    chk("t1_rtid", bus.resp_trans_id_o, 5);
    chk("t1_rerr", bus.resp_err_o, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t1_count0", bus.count_o, 0);

    // 2: fill, then stall while a response frees tag 1
    drive(1, 1, 0, 0, 0);
    chk("t2_tag0", bus.alloc_tag_o, 0);
    tick();
    drive(1, 2, 0, 0, 0);
    chk("t2_tag1", bus.alloc_tag_o, 1);
    chk("t2_ready1", bus.alloc_ready_o, 1);
    tick();
    drive(1, 6, 1, 1, 0);
    chk("t2_full_ready", bus.alloc_ready_o, 0);
    chk("t2_full_count", bus.count_o, 2);
    chk("t2_rvalid", bus.resp_valid_o, 1);
    chk("t2_rtid", bus.resp_trans_id_o, 2);
    tick();
    drive(1, 6, 0, 0, 0);
    chk("t2_regrant_ready", bus.alloc_ready_o, 1);
    chk("t2_regrant_tag", bus.alloc_tag_o, 1);
    chk("t2_count1", bus.count_o, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t2_count2", bus.count_o, 2);

    // 3: flush kills both, responses dropped
    drive(0, 0, 0, 0, 1);
    chk("t3_flush_ready", bus.alloc_ready_o, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("t3_k0", bus.resp_killed_o, 1);
    chk("t3_v0", bus.resp_valid_o, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    chk("t3_k1", bus.resp_killed_o, 1);
    chk("t3_v1", bus.resp_valid_o, 0);
    chk("t3_cnt1", bus.count_o, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t3_count", bus.count_o, 0);
    chk("t3_empty", bus.empty_o, 1);

    // 4: flush together with a LIVE response
    drive(1, 3, 0, 0, 0);
    tick();
    drive(1, 4, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 1);
    chk("t4_rvalid", bus.resp_valid_o, 1);
    chk("t4_rtid", bus.resp_trans_id_o, 3);
    chk("t4_killed", bus.resp_killed_o, 0);
    chk("t4_ready", bus.alloc_ready_o, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    chk("t4_count", bus.count_o, 1);
    chk("t4_ready_after", bus.alloc_ready_o, 1);
    chk("t4_tag_after", bus.alloc_tag_o, 0);
    chk("t4_k1", bus.resp_killed_o, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t4_count0", bus.count_o, 0);

    // 5: response on a free tag, then reset mid-operation
    drive(0, 0, 1, 1, 0);
    chk("t5_err", bus.resp_err_o, 1);
    chk("t5_rvalid", bus.resp_valid_o, 0);
    tick();
    drive(1, 7, 0, 0, 0);
    chk("t5_count_unch", bus.count_o, 0);
    tick();
    drive(1, 6, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t5_count2", bus.count_o, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 0, 0);
    chk("t5_rst_count", bus.count_o, 0);
    chk("t5_rst_empty", bus.empty_o, 1);
    chk("t5_rst_err", bus.resp_err_o, 1);
    tick();

    // 6: randomized traffic against a scoreboard
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0; m_killed[i] = 1'b0; m_tid[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic       av, rv, rt, fl, e_ready, e_free, e_live, e_dead, fire;
      logic [2:0] aid;
      int         e_tag, e_cnt;
      av  = ($urandom_range(0, 9) < 6);
      aid = 3'($urandom_range(0, 7));
      rv  = $urandom_range(0, 1) == 1;
      rt  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 31) == 0);
      drive(av, aid, rv, rt, fl);
      e_free = 1'b0; e_tag = 0; e_cnt = 0;
      for (int i = NR - 1; i >= 0; i--) if (!m_valid[i]) begin e_free = 1'b1; e_tag = i; end
      for (int i = 0; i < NR; i++) e_cnt += int'(m_valid[i]);
      e_ready = e_free && !fl;
      e_live  = rv && m_valid[rt] && !m_killed[rt];
      e_dead  = rv && m_valid[rt] && m_killed[rt];
      chk("rnd_ready", bus.alloc_ready_o, e_ready);
      if (e_ready) chk("rnd_tag", bus.alloc_tag_o, e_tag);
      chk("rnd_rvalid", bus.resp_valid_o, e_live);
      if (e_live) chk("rnd_rtid", bus.resp_trans_id_o, m_tid[rt]);
      chk("rnd_killed", bus.resp_killed_o, e_dead);
      chk("rnd_err", bus.resp_err_o, rv && !m_valid[rt]);
      chk("rnd_count", bus.count_o, e_cnt);
      fire = av && e_ready;
      if (fl) for (int i = 0; i < NR; i++) if (m_valid[i]) m_killed[i] = 1'b1;
      if (rv && m_valid[rt]) begin m_valid[rt] = 1'b0; m_killed[rt] = 1'b0; end
      if (fire) begin m_valid[e_tag] = 1'b1; m_killed[e_tag] = 1'b0; m_tid[e_tag] = aid; end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
